// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// grant identities and transfer lengths.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_IFETCH = 2'd1,
    MC_LOAD   = 2'd2,
    MC_STORE  = 2'd3
  } mc_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  // Any length other than byte/half collapses to a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_BYTE: return LEN_BYTE;
      LEN_HALF: return LEN_HALF;
      default:  return LEN_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the single 8-bit RAM/IO port between instruction fetch and
// load/store, sequencing multi-byte reads and writes one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  mc_state_e   state, state_nxt;
  grant_e      last_grant, last_grant_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [2:0]  len;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] word;
  logic [31:0] cur_a;
  logic [1:0]  rd_byte;
  logic        grant_if, grant_ls;
  logic        capture;
  logic        io_stall;
  logic        is_read;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    grant_if       = 1'b0;
    grant_ls       = 1'b0;
    capture        = 1'b0;
    mem_a          = 32'd0;
    mem_wr         = 1'b0;
    mem_dout       = 8'd0;
    if_done        = 1'b0;
    ls_done        = 1'b0;
    cur_a          = base + {29'd0, cnt};
    rd_byte        = cnt[1:0] - 2'd1;
    io_stall       = (cur_a[17:16] == IO_BASE_HI) && io_buffer_full;
    is_read        = (state == MC_IFETCH) || (state == MC_LOAD);

    if (rst) begin
      // outputs stay at their zero defaults; the transfer is abandoned
    end else if (!rdy) begin
      // While paused, re-present the address whose byte is still owed so the
      // RAM's one-cycle latency lines up again when rdy returns.
      if (is_read && cnt != 3'd0 && cnt <= len)
        mem_a = cur_a - 32'd1;
    end else begin
      case (state)
        MC_IDLE: begin
          if (!rollback) begin
            if (if_valid && (!ls_valid || last_grant == GRANT_LS)) begin
              grant_if       = 1'b1;
              state_nxt      = MC_IFETCH;
              last_grant_nxt = GRANT_IF;
              cnt_nxt        = 3'd0;
            end else if (ls_valid) begin
              grant_ls       = 1'b1;
              state_nxt      = ls_wr ? MC_STORE : MC_LOAD;
              last_grant_nxt = GRANT_LS;
              cnt_nxt        = 3'd0;
            end
          end
        end
        MC_IFETCH, MC_LOAD: begin
          // cnt: address phase 0..len-1, capture phase 1..len, done at len+1
          if (cnt < len)
            mem_a = cur_a;
          capture = (cnt != 3'd0) && (cnt <= len);
          cnt_nxt = cnt + 3'd1;
          if (rollback) begin
            state_nxt = MC_IDLE;
            capture   = 1'b0;
          end else if (cnt == len + 3'd1) begin
            state_nxt = MC_IDLE;
            if (state == MC_IFETCH) if_done = 1'b1;
            else                    ls_done = 1'b1;
          end
        end
        MC_STORE: begin
          if (cnt == len) begin
            ls_done   = 1'b1;
            state_nxt = MC_IDLE;
          end else begin
            mem_a = cur_a;
            if (!io_stall) begin
              mem_wr   = 1'b1;
              mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
              cnt_nxt  = cnt + 3'd1;
            end
          end
        end
        default: state_nxt = MC_IDLE;
      endcase
    end

    if_data  = if_done ? word : 32'd0;
    ls_rdata = (ls_done && state == MC_LOAD) ? word : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MC_IDLE;
      cnt        <= 3'd0;
      last_grant <= GRANT_LS;
    end else if (rdy) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Transfer descriptor and assembled word: qualified by state, so no reset.
  always_ff @(posedge clk) begin
    if (grant_if) begin
      base <= if_addr;
      len  <= LEN_WORD;
      word <= 32'd0;
    end else if (grant_ls) begin
      base  <= ls_addr;
      len   <= norm_len(ls_len);
      wdata <= ls_wdata;
      word  <= 32'd0;
    end else if (capture) begin
      word[{rd_byte, 3'b000} +: 8] <= mem_din;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected completions
// and RAM writes; a negedge monitor pops and compares them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_valid = 1'b0;
  logic        ls_wr = 1'b0;
  logic [2:0]  ls_len = 3'd0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
  } done_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  done_t if_q[$];
  done_t ls_q[$];
  wr_t   wr_q[$];
  done_t de;
  wr_t   we;

  mem_ctrl #(.IO_BASE_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h00;
      32'h103: return 8'h00;
      32'h200: return 8'hF0;
      32'h204: return 8'h11;
      32'h205: return 8'h22;
      32'h206: return 8'h33;
      32'h207: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  // Synchronous RAM: data for this cycle's address appears next cycle.
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    at(c);
    @(negedge clk);
  endtask

  task automatic ls_req(input int c, input logic wr, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] wd);
    at(c);
    ls_valid = 1'b1;
    ls_wr    = wr;
    ls_len   = len;
    ls_addr  = addr;
    ls_wdata = wd;
  endtask

  function automatic done_t mk_done(input int c, input logic [31:0] d, input bit cd);
    done_t t;
    t.cyc = c; t.data = d; t.chk_data = cd;
    return t;
  endfunction

  function automatic wr_t mk_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    wr_t t;
    t.cyc = c; t.a = a; t.d = d;
    return t;
  endfunction

  always @(negedge clk) begin
    if (if_done) begin
      if (if_q.size() == 0) chk("if_done_unexpected", {31'd0, if_done}, 32'd0);
      else begin
        de = if_q.pop_front();
        chk("if_done_cycle", cyc, de.cyc);
        chk("if_data", if_data, de.data);
      end
    end
    if (ls_done) begin
      if (ls_q.size() == 0) chk("ls_done_unexpected", {31'd0, ls_done}, 32'd0);
      else begin
        de = ls_q.pop_front();
        chk("ls_done_cycle", cyc, de.cyc);
        if (de.chk_data) chk("ls_rdata", ls_rdata, de.data);
      end
    end
    if (mem_wr) begin
      if (wr_q.size() == 0) chk("write_unexpected", mem_a, 32'hFFFF_FFFF);
      else begin
        we = wr_q.pop_front();
        chk("write_cycle", cyc, we.cyc);
        chk("write_addr", mem_a, we.a);
        chk("write_data", {24'd0, mem_dout}, {24'd0, we.d});
      end
    end
  end

  initial begin
    // reset state
    at_neg(2);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);

    // contention at reset release: IF first, then LS, then the re-raised IF
    at(4);
    rst = 1'b0;
    if_valid = 1'b1; if_addr = 32'h100;
    ls_req(4, 1'b0, 3'd1, 32'h200, 32'd0);
    if_q.push_back(mk_done(10, 32'h0000_0513, 1'b1));
    ls_q.push_back(mk_done(14, 32'h0000_00F0, 1'b1));
    if_q.push_back(mk_done(21, 32'h4433_2211, 1'b1));
    for (int k = 0; k < 4; k++) begin
      at_neg(5 + k);
      chk("if_mem_a", mem_a, 32'h100 + k);
      chk("if_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    at(10); if_addr = 32'h204;
    at(14); ls_valid = 1'b0;
    at(21); if_valid = 1'b0;

    // LW
    ls_req(24, 1'b0, 3'd4, 32'h204, 32'd0);
    ls_q.push_back(mk_done(30, 32'h4433_2211, 1'b1));
    at(30); ls_valid = 1'b0;

    // SH: only the two low bytes are written
    ls_req(32, 1'b1, 3'd2, 32'h300, 32'hAABB_CCDD);
    wr_q.push_back(mk_wr(33, 32'h300, 8'hDD));
    wr_q.push_back(mk_wr(34, 32'h301, 8'hCC));
    ls_q.push_back(mk_done(35, 32'd0, 1'b0));
    at(35); ls_valid = 1'b0;

    // SB to IO space with the buffer full for three cycles
    ls_req(38, 1'b1, 3'd1, 32'h0003_0000, 32'h0000_005A);
    io_buffer_full = 1'b1;
    wr_q.push_back(mk_wr(42, 32'h0003_0000, 8'h5A));
    ls_q.push_back(mk_done(43, 32'd0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      at_neg(39 + k);
      chk("io_stall_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    at(42); io_buffer_full = 1'b0;
    at(43); ls_valid = 1'b0;

    // rollback in cycle A+3 of an IFETCH; a following LB proves IDLE
    at(46); if_valid = 1'b1; if_addr = 32'h100;
    at(49); rollback = 1'b1; if_valid = 1'b0;
    at(50); rollback = 1'b0;
    ls_req(50, 1'b0, 3'd1, 32'h200, 32'd0);
    ls_q.push_back(mk_done(53, 32'h0000_00F0, 1'b1));
    at(53); ls_valid = 1'b0;

    // rollback during SW does not abort it
    ls_req(56, 1'b1, 3'd4, 32'h304, 32'h1122_3344);
    wr_q.push_back(mk_wr(57, 32'h304, 8'h44));
    wr_q.push_back(mk_wr(58, 32'h305, 8'h33));
    wr_q.push_back(mk_wr(59, 32'h306, 8'h22));
    wr_q.push_back(mk_wr(60, 32'h307, 8'h11));
    ls_q.push_back(mk_done(61, 32'd0, 1'b0));
    at(58); rollback = 1'b1;
    at(59); rollback = 1'b0;
    at(61); ls_valid = 1'b0;

    // rdy low for two cycles mid-load delays completion by two
    ls_req(64, 1'b0, 3'd4, 32'h204, 32'd0);
    ls_q.push_back(mk_done(72, 32'h4433_2211, 1'b1));
    at(66); rdy = 1'b0;
    at(68); rdy = 1'b1;
    at(72); ls_valid = 1'b0;

    // rollback in the cycle an LB would complete suppresses ls_done
    ls_req(76, 1'b0, 3'd1, 32'h200, 32'd0);
    at(79); rollback = 1'b1; ls_valid = 1'b0;
    at(80); rollback = 1'b0;

    // LH
    ls_req(82, 1'b0, 3'd2, 32'h204, 32'd0);
    ls_q.push_back(mk_done(86, 32'h0000_2211, 1'b1));
    at(86); ls_valid = 1'b0;

    // reset mid-load: no completion
    ls_req(88, 1'b0, 3'd4, 32'h204, 32'd0);
    at(90); rst = 1'b1; ls_valid = 1'b0;
    at(91); rst = 1'b0;

    // illegal length 3 behaves as a word
    ls_req(92, 1'b0, 3'd3, 32'h100, 32'd0);
    ls_q.push_back(mk_done(98, 32'h0000_0513, 1'b1));
    at(98); ls_valid = 1'b0;

    // rollback in IDLE blocks the grant for that cycle
    at(100); rollback = 1'b1;
    ls_req(100, 1'b0, 3'd1, 32'h200, 32'd0);
    ls_q.push_back(mk_done(104, 32'h0000_00F0, 1'b1));
    at(101); rollback = 1'b0;
    at(104); ls_valid = 1'b0;

    at_neg(108);
    chk("if_missing", if_q.size(), 32'd0);
    chk("ls_missing", ls_q.size(), 32'd0);
    chk("write_missing", wr_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller that shares the single 8-bit RAM/IO port between two requesters.
- Requester 1 is the instruction-fetch path, which needs 4-byte words.
- Requester 2 is the load/store path, which needs 1/2/4-byte loads and stores, with stores issued only at commit.
- Sequences multi-byte transfers, handles the one-cycle RAM read latency, throttles IO stores on io_buffer_full, and aborts speculative reads on rollback.

Parameters:
- IO_BASE_HI, 2'b11: value of addr[17:16] that marks the IO space; stores to this space obey io_buffer_full.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = pause
- rollback  in  1  flush of speculative work
- mem_din  in  8  RAM read data; holds data for the address driven in the previous cycle
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO write buffer full
- if_valid  in  1  fetch request; held until if_done or rollback
- if_addr  in  32  fetch word address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word, little-endian
- ls_valid  in  1  load/store request; held until ls_done
- ls_wr  in  1  1 = store
- ls_len  in  3  byte count: 1, 2 or 4
- ls_addr  in  32  start byte address
- ls_wdata  in  32  store data; byte k = bits [8k+7:8k]
- ls_done  out  1  one-cycle pulse: transfer complete
- ls_rdata  out  32  load data; unused upper bytes zero; sign extension belongs to the requester

Behaviour:
- Reset:
  - state = IDLE, all outputs 0, byte counter 0.
  - last_grant = LS, so the first contention goes to IF.
  - Reset mid-transfer abandons the transfer immediately; no done pulse is produced.
- rdy low: all state frozen; mem_wr forced 0; done outputs hold 0.
- States: IDLE, IFETCH, LOAD, STORE.
- IDLE arbitration, with A = the cycle the request is seen in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not in last_grant is granted; last_grant is updated on each grant.
  - Granted LS with ls_wr=1 -> STORE; ls_wr=0 -> LOAD; granted IF -> IFETCH with a length of 4.
  - On grant the controller latches addr, len and wdata. The requester must keep its inputs stable anyway.
- No new grant is made in the cycle a done pulse is high. The requester drops valid in that cycle; the earliest re-grant is the following cycle.
- Read (IFETCH/LOAD), N bytes:
  - mem_a = base+0 .. base+N-1 in cycles A+1 .. A+N, mem_wr = 0.
  - Byte k is captured from mem_din in cycle A+k+2.
  - Done pulses in cycle A+N+2, with the assembled word valid in that same cycle. An IFETCH therefore completes in cycle A+6.
- Store, N bytes:
  - Byte k goes out as mem_a = base+k, mem_dout = byte k, mem_wr = 1.
  - With no stalls, bytes go out in cycles A+1 .. A+N.
  - IO stall: in a cycle where the address is in IO space and io_buffer_full = 1, drive mem_wr = 0, keep the counter, and retry the next cycle.
  - ls_done pulses the cycle after the last byte is written.
- Rollback:
  - Aborts IFETCH and LOAD immediately; next state is IDLE with mem_wr = 0 and no done pulse.
  - A STORE in progress is committed and is not aborted.
  - Rollback in IDLE blocks any grant in that cycle.
  - Rollback in the same cycle a read would pulse done: the done pulse is suppressed.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- ls_len values other than 1/2/4 are treated as 4.
- mem_dout = 0 whenever mem_wr = 0.

Decomposition:
- const.v gains macros:
  - state encodings MC_IDLE / MC_IFETCH / MC_LOAD / MC_STORE (2 bits)
  - LEN_BYTE / LEN_HALF / LEN_WORD
  - GRANT_IF / GRANT_LS
- Existing TRUE/FALSE/ZERO macros are reused.
- Single flat module. A byte-assembly shift register is kept inline; no sub-module is warranted.

Test Plan:
- IF-only fetch: RAM[0x100..0x103] = 13,05,00,00, if_valid in cycle 0 -> if_done in cycle 6 with if_data = 0x00000513; mem_a sequence 0x100..0x103.
- LB then LW:
  - LB: ls_len = 1, addr 0x200 holding 0xF0 -> ls_done in cycle 3, ls_rdata = 0x000000F0.
  - LW: at 0x204 -> ls_rdata equals the little-endian word at 0x204.
- SH store: ls_wr = 1, ls_len = 2, ls_addr = 0x300, ls_wdata = 0xAABBCCDD -> writes 0xDD@0x300 and 0xCC@0x301 in cycles 1–2; ls_done in cycle 3; 0xAA/0xBB never written.
- Contention:
  - if_valid and ls_valid both raised at reset release -> IF granted first.
  - LS is granted the cycle after if_done.
  - A second simultaneous pair -> LS is then not starved.
- IO store stall: SB to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write of the byte; ls_done the next cycle.
- Rollback:
  - Rollback in cycle 3 of an IFETCH -> no if_done, state returns to IDLE.
  - Rollback during an SW -> all 4 bytes still written and ls_done pulses.
  - rdy low for 2 cycles mid-load -> completion delayed by exactly 2 cycles.
